// File: rtl/regfile_scoreboard.sv
// Integer register file with a reset sweep, write-to-read bypass,
// a per-register busy scoreboard and a scoreboard flush.
// x0 is hardwired to zero and can never be marked busy.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        init_done,
    input  logic [NREAD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NREAD*DATA_WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]            rd_busy,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        alloc_en,
    input  logic [ADDR_WIDTH-1:0]       alloc_addr,
    input  logic                        flush,
    output logic [ADDR_WIDTH:0]         busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   ra;

    // Population count of the busy vector; result always fits ADDR_WIDTH+1 bits.
    function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next busy vector: flush beats alloc, alloc beats writeback clear.
    always_comb begin
        busy_next = busy_q;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wen && waddr != '0) begin
                busy_next[waddr] = 1'b0;
            end
            if (alloc_en && alloc_addr != '0) begin
                busy_next[alloc_addr] = 1'b1;
            end
        end
    end

    // Control FSM: sweep every entry after reset, then track busy bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            ptr       <= '0;
            busy_q    <= '0;
            busy_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == S_INIT) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) begin
                state     <= S_RUN;
                init_done <= 1'b1;
            end
        end else begin
            busy_q   <= busy_next;
            busy_cnt <= popcount(busy_next);
        end
    end

    // Storage: zeroed one entry per cycle during the sweep, written by writeback in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[ptr] <= '0;
            end else if (wen && waddr != '0) begin
                mem[waddr] <= wdata;
            end
        end
    end

    // Combinational read ports with writeback bypass; a same-cycle alloc keeps the old busy bit visible.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (state == S_RUN && ra != '0) begin
                if (wen && waddr == ra) begin
                    rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wdata;
                    rd_busy[k] = (alloc_en && !flush && alloc_addr == ra) ? busy_q[ra] : 1'b0;
                end else begin
                    rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
                    rd_busy[k] = busy_q[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default parameters, two read ports).
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    int total = 0;
    int bad   = 0;
    int n;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_cnt   (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setrd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0; rd_addr = '0;

        // Reset state
        tick(); tick(); tick();
        setrd(5'd5, 5'd3);
        #1;
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_busy_cnt",  64'(busy_cnt),  64'd0);
        chk("rst_rd_busy",   64'(rd_busy),   64'd0);
        chk("rst_rd_data",   rd_data,        64'd0);

        // Sweep with ignored writeback/alloc/flush traffic
        rst = 1'b0;
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
        alloc_en = 1'b1; alloc_addr = 5'd5;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) begin
                chk("init_rd_data", rd_data, 64'd0);
                chk("init_rd_busy", 64'(rd_busy), 64'd0);
            end
            if (init_done) begin
                n = i;
                break;
            end
        end
        wen = 1'b0; alloc_en = 1'b0;
        chk("sweep_cycles", 64'(n), 64'd32);
        setrd(5'd5, 5'd0);
        #1;
        chk("x5_after_init", rd_data, 64'd0);
        chk("cnt_after_init", 64'(busy_cnt), 64'd0);
        chk("busy_after_init", 64'(rd_busy), 64'd0);

        // Write x3 with same-cycle bypass on port 0, registered read on port 1
        wen = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
        setrd(5'd3, 5'd0);
        #1;
        chk("bypass_p0", rd_data, 64'h0000_0000_1234_5678);
        chk("bypass_busy", 64'(rd_busy), 64'd0);
        tick();
        wen = 1'b0;
        setrd(5'd0, 5'd3);
        #1;
        chk("read_p1_x3", rd_data, 64'h1234_5678_0000_0000);

        // Write to x0 is dropped
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        setrd(5'd0, 5'd0);
        #1;
        chk("x0_no_bypass", rd_data, 64'd0);
        tick();
        wen = 1'b0;
        #1;
        chk("x0_reads_zero", rd_data, 64'd0);

        // Scoreboard set on alloc, cleared on writeback
        alloc_en = 1'b1; alloc_addr = 5'd7;
        setrd(5'd7, 5'd0);
        tick();
        alloc_en = 1'b0;
        #1;
        chk("x7_busy", 64'(rd_busy), 64'd1);
        chk("x7_cnt1", 64'(busy_cnt), 64'd1);
        wen = 1'b1; waddr = 5'd7; wdata = 32'hAB;
        #1;
        chk("x7_wb_busy", 64'(rd_busy), 64'd0);
        chk("x7_wb_data", rd_data, 64'hAB);
        tick();
        wen = 1'b0;
        #1;
        chk("x7_cnt0", 64'(busy_cnt), 64'd0);
        chk("x7_data", rd_data, 64'hAB);

        // Simultaneous alloc and writeback on busy x9
        alloc_en = 1'b1; alloc_addr = 5'd9;
        setrd(5'd9, 5'd0);
        tick();
        alloc_en = 1'b0;
        #1;
        chk("x9_cnt1", 64'(busy_cnt), 64'd1);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h55;
        #1;
        chk("x9_same_busy", 64'(rd_busy), 64'd1);
        chk("x9_same_data", rd_data, 64'h55);
        tick();
        alloc_en = 1'b0; wen = 1'b0;
        #1;
        chk("x9_data", rd_data, 64'h55);
        chk("x9_busy", 64'(rd_busy), 64'd1);
        chk("x9_cnt", 64'(busy_cnt), 64'd1);

        // Retire x9, then allocate x1, x2, x4 and flush with a competing alloc
        wen = 1'b1; waddr = 5'd9; wdata = 32'h66;
        tick();
        wen = 1'b0;
        #1;
        chk("x9_retired_cnt", 64'(busy_cnt), 64'd0);
        alloc_en = 1'b1; alloc_addr = 5'd1;
        tick();
        alloc_addr = 5'd2;
        tick();
        alloc_addr = 5'd4;
        tick();
        alloc_en = 1'b0;
        setrd(5'd1, 5'd4);
        #1;
        chk("pre_flush_cnt", 64'(busy_cnt), 64'd3);
        chk("pre_flush_busy", 64'(rd_busy), 64'd3);
        flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd6;
        tick();
        flush = 1'b0; alloc_en = 1'b0;
        #1;
        chk("flush_cnt", 64'(busy_cnt), 64'd0);
        chk("flush_busy_1_4", 64'(rd_busy), 64'd0);
        setrd(5'd6, 5'd2);
        #1;
        chk("flush_busy_6_2", 64'(rd_busy), 64'd0);

        // Reset mid-operation, then again mid-sweep
        alloc_en = 1'b1; alloc_addr = 5'd10;
        tick();
        alloc_addr = 5'd11;
        tick();
        alloc_en = 1'b0;
        #1;
        chk("pre_rst_cnt", 64'(busy_cnt), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_init_done", 64'(init_done), 64'd0);
        chk("rst2_cnt", 64'(busy_cnt), 64'd0);
        for (int i = 0; i < 16; i++) tick();
        chk("mid_sweep_init_done", 64'(init_done), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst3_init_done", 64'(init_done), 64'd0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (init_done) begin
                n = i;
                break;
            end
        end
        chk("resweep_cycles", 64'(n), 64'd32);
        chk("resweep_cnt", 64'(busy_cnt), 64'd0);
        for (int i = 0; i < 32; i++) begin
            setrd(5'(i), 5'(31 - i));
            #1;
            chk("all_zero_data", rd_data, 64'd0);
            chk("all_zero_busy", 64'(rd_busy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Next-generation integer register file for the LemonPC core. It is parametrised in depth, width and read-port count. It adds four things: a synchronous reset that sweeps every entry to zero, write-to-read bypass, a per-register busy scoreboard (set on issue, cleared on writeback) and a flush. It sits between decode, which issues reads and allocates destinations, and writeback, which writes results.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 32, register data width.
NREAD, 2, number of independent read ports (>=1).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
init_done  output  1  1 once the reset sweep completes.
rd_addr  input  NREAD*ADDR_WIDTH  read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
rd_data  output  NREAD*DATA_WIDTH  read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
rd_busy  output  NREAD  1 = the register on port k has a pending producer.
wen  input  1  writeback enable.
waddr  input  ADDR_WIDTH  writeback index.
wdata  input  DATA_WIDTH  writeback data.
alloc_en  input  1  mark alloc_addr busy (instruction issued).
alloc_addr  input  ADDR_WIDTH  destination being allocated.
flush  input  1  clear all busy bits.
busy_cnt  output  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- States: INIT, RUN.
- rst=1 (at any time, including mid-sweep or mid-operation):
  - Next state INIT; sweep pointer = 0; all busy bits = 0; busy_cnt = 0; init_done = 0.
- INIT:
  - One entry cleared per cycle at the sweep pointer; pointer increments.
  - After entry 2**ADDR_WIDTH-1 is cleared, the next state is RUN and init_done = 1. This is 2**ADDR_WIDTH cycles after rst deasserts.
  - wen, alloc_en and flush are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- RUN, write:
  - wen with waddr != 0 writes wdata at posedge.
  - wen with waddr == 0 is dropped; x0 always reads 0 and is never busy.
- RUN, read:
  - Combinational, 0-cycle latency.
  - Bypass: if wen && waddr == rd_addr[k] && rd_addr[k] != 0, then rd_data[k] = wdata and rd_busy[k] = 0, unless the same-cycle alloc rule below applies.
  - All ports resolve independently; identical addresses on several ports are legal.
- Busy bits, per index, priority high to low:
  1. flush: clear all bits next cycle; a same-cycle alloc_en is ignored.
  2. alloc_en at index: set (WAW re-allocation of a busy register is legal; the bit stays set).
  3. wen at index: clear.
  - alloc_en and wen to the same index in the same cycle: the bit ends set. The new producer wins; the data is still written.
  - alloc_en to index 0: ignored.
  - rd_busy reflects the registered bit, except during bypass. If alloc_en targets the read address in the same cycle, rd_busy for that cycle still shows the old registered value.
- busy_cnt:
  - Registered population count of the busy bits, updated with them; range 0..2**ADDR_WIDTH-1.
  - Set+clear of the same index nets 0; alloc of an already-busy index adds 0.
  - flush makes it 0 next cycle.
- Reset values: init_done = 0, busy_cnt = 0, rd_busy = 0, rd_data = 0.
- No X propagation: every entry is defined after INIT.

Test Plan:
- Reset sweep: hold rst 3 cycles, release; with default ADDR_WIDTH=5, init_done rises exactly 32 cycles later. During INIT, wen to x5 with data 0xDEAD is ignored; after init, x5 reads 0.
- Write/read/bypass: write 0x12345678 to x3; the same cycle, port0 reads x3 and shows 0x12345678 (bypass); the next cycle, port1 reads x3 and shows 0x12345678. A write of 0xFFFFFFFF to x0 reads back 0.
- Scoreboard: alloc x7 -> next cycle rd_busy=1 and busy_cnt=1. Then wen x7 with 0xAB: that cycle rd_busy=0 and rd_data=0xAB; next cycle busy_cnt=0.
- Simultaneous alloc+write: x9 is busy; in one cycle alloc x9 and wen x9 with 0x55 -> next cycle x9 reads 0x55, rd_busy=1, busy_cnt unchanged at 1.
- Flush: alloc x1, x2, x4 on consecutive cycles (busy_cnt=3); assert flush together with alloc x6 -> next cycle busy_cnt=0 and all rd_busy=0.
- Reset mid-operation: with busy_cnt=2, assert rst midway through a second sweep -> init_done stays 0 and the sweep restarts; 32 cycles after release, init_done=1 and all registers read 0.
